// File: rtl/axis_demux_1to2.sv
// ---------------------------------------------------------------------------
// axis_demux_1to2
//   Packet-aware 1:2 AXI-Stream demultiplexer. Each packet on the slave port
//   is steered to output 1 (sel=0) or output 2 (sel=1). The route is chosen
//   on the first beat and held until s_last is accepted. Each output owns a
//   2-entry skid slice, so s_ready never depends combinationally on m_ready_*.
//
//   Optional feature macro: AXIS_DEMUX_PKT_CNT_EN
//     defined     -> pkt_cnt_k counts delivered last-beats on output k (wraps)
//     not defined -> pkt_cnt_k tied to 0
//
//   Ports (top):
//     clk, reset_n               clock, async active-low reset
//     sel                        route select, sampled at packet start only
//     s_data/s_valid/s_ready/s_last          slave stream
//     m_data_k/m_valid_k/m_ready_k/m_last_k  master streams, k = 1,2
//     pkt_cnt_1/pkt_cnt_2        delivered-packet counters
// ---------------------------------------------------------------------------

// Per-output 2-entry skid slice. Entry 0 is always the head.
//   i_push      write {i_data,i_last}; caller guarantees !o_full
//   i_ready     downstream ready; pops the head when valid
//   o_full      count == 2
//   o_valid/o_data/o_last  head entry (data/last forced 0 when empty)
//   o_pkt_cnt   delivered last-beat counter (0 when feature disabled)
module axis_demux_slice #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_full,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_pkt_cnt
);
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_d0, r_d1;
    logic              r_l0, r_l1;
    logic              w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_full  = (r_cnt == 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = o_valid ? r_d0 : '0;
    assign o_last  = o_valid ? r_l0 : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_l0  <= 1'b0;
            r_l1  <= 1'b0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    // fill the first free slot; head only moves when empty
                    if (r_cnt == 2'd0) begin
                        r_d0 <= i_data;
                        r_l0 <= i_last;
                    end else begin
                        r_d1 <= i_data;
                        r_l1 <= i_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // count unchanged; new beat lands behind any survivor
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_data;
                        r_l0 <= i_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= i_data;
                        r_l1 <= i_last;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [CNT_W-1:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pkt_cnt <= '0;
        else if (w_pop && r_l0)
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end

    assign o_pkt_cnt = r_pkt_cnt;
`else
    assign o_pkt_cnt = '0;
`endif
endmodule

module axis_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DATA_W-1:0] m_data_1,
    output logic              m_valid_1,
    input  logic              m_ready_1,
    output logic              m_last_1,
    output logic [DATA_W-1:0] m_data_2,
    output logic              m_valid_2,
    input  logic              m_ready_2,
    output logic              m_last_2,
    output logic [CNT_W-1:0]  pkt_cnt_1,
    output logic [CNT_W-1:0]  pkt_cnt_2
);
    localparam int NUM_OUT = 2;

    typedef enum logic [1:0] {IDLE, ROUTE_1, ROUTE_2} state_t;

    state_t                          r_state;
    logic                            w_tgt;     // 0 -> output 1, 1 -> output 2
    logic                            w_acc;
    logic [NUM_OUT-1:0]              w_push;
    logic [NUM_OUT-1:0]              w_full;
    logic [NUM_OUT-1:0]              w_m_ready;
    logic [NUM_OUT-1:0]              w_m_valid;
    logic [NUM_OUT-1:0]              w_m_last;
    logic [NUM_OUT-1:0][DATA_W-1:0]  w_m_data;
    logic [NUM_OUT-1:0][CNT_W-1:0]   w_pkt_cnt;

    // sel only matters in IDLE; inside a packet the route is locked
    always_comb begin
        w_tgt = sel;
        case (r_state)
            ROUTE_1: w_tgt = 1'b0;
            ROUTE_2: w_tgt = 1'b1;
            default: w_tgt = sel;
        endcase
    end

    assign s_ready = !w_full[w_tgt];
    assign w_acc   = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (w_acc) begin
            case (r_state)
                IDLE:    if (!s_last) r_state <= sel ? ROUTE_2 : ROUTE_1;
                ROUTE_1,
                ROUTE_2: if (s_last) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_m_ready = {m_ready_2, m_ready_1};

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign w_push[g] = w_acc && (w_tgt == g[0]);

        axis_demux_slice #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slice (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_push    (w_push[g]),
            .i_data    (s_data),
            .i_last    (s_last),
            .i_ready   (w_m_ready[g]),
            .o_full    (w_full[g]),
            .o_valid   (w_m_valid[g]),
            .o_data    (w_m_data[g]),
            .o_last    (w_m_last[g]),
            .o_pkt_cnt (w_pkt_cnt[g])
        );
    end

    assign m_data_1  = w_m_data[0];
    assign m_valid_1 = w_m_valid[0];
    assign m_last_1  = w_m_last[0];
    assign pkt_cnt_1 = w_pkt_cnt[0];
    assign m_data_2  = w_m_data[1];
    assign m_valid_2 = w_m_valid[1];
    assign m_last_2  = w_m_last[1];
    assign pkt_cnt_2 = w_pkt_cnt[1];
endmodule

// File: tb/tb_axis_demux_1to2.sv
// Directed, table-driven bench for axis_demux_1to2 (CNT_W = 4 so the
// counter wrap is reachable in a few packets).
module tb_axis_demux_1to2;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sel;
    logic [DATA_W-1:0] s_data;
    logic              s_valid, s_ready, s_last;
    logic [DATA_W-1:0] m_data_1, m_data_2;
    logic              m_valid_1, m_valid_2, m_ready_1, m_ready_2, m_last_1, m_last_2;
    logic [CNT_W-1:0]  pkt_cnt_1, pkt_cnt_2;

    axis_demux_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data_1(m_data_1), .m_valid_1(m_valid_1), .m_ready_1(m_ready_1), .m_last_1(m_last_1),
        .m_data_2(m_data_2), .m_valid_2(m_valid_2), .m_ready_2(m_ready_2), .m_last_2(m_last_2),
        .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sr;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       v2;
        logic [7:0] d2;
        logic       l2;
        int         c1;
        int         c2;
    } out_t;

    typedef struct {
        logic       sel;
        logic [7:0] d;
        logic       v;
        logic       l;
        logic       r1;
        logic       r2;
        out_t       e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic se, logic [7:0] d, logic v, logic l, logic r1, logic r2,
                                logic sr, logic v1, logic [7:0] d1, logic l1,
                                logic v2, logic [7:0] d2, logic l2, int c1, int c2);
        vec_t t;
        t.sel = se; t.d = d; t.v = v; t.l = l; t.r1 = r1; t.r2 = r2;
        t.e.sr = sr; t.e.v1 = v1; t.e.d1 = d1; t.e.l1 = l1;
        t.e.v2 = v2; t.e.d2 = d2; t.e.l2 = l2; t.e.c1 = c1; t.e.c2 = c2;
        return t;
    endfunction

    // raw packet count -> expected counter port value
    function automatic logic [31:0] cx(int v);
`ifdef AXIS_DEMUX_PKT_CNT_EN
        return 32'(v % 16);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, exp);
        end
    endtask

    task automatic chk(input string nm, input out_t e);
        cmp(nm, "s_ready",   32'(s_ready),   32'(e.sr));
        cmp(nm, "m_valid_1", 32'(m_valid_1), 32'(e.v1));
        cmp(nm, "m_data_1",  32'(m_data_1),  32'(e.d1));
        cmp(nm, "m_last_1",  32'(m_last_1),  32'(e.l1));
        cmp(nm, "m_valid_2", 32'(m_valid_2), 32'(e.v2));
        cmp(nm, "m_data_2",  32'(m_data_2),  32'(e.d2));
        cmp(nm, "m_last_2",  32'(m_last_2),  32'(e.l2));
        cmp(nm, "pkt_cnt_1", 32'(pkt_cnt_1), cx(e.c1));
        cmp(nm, "pkt_cnt_2", 32'(pkt_cnt_2), cx(e.c2));
    endtask

    // drive, clock once, sample 1 time unit after the edge
    task automatic apply(input string nm, input vec_t t);
        sel = t.sel; s_data = t.d; s_valid = t.v; s_last = t.l;
        m_ready_1 = t.r1; m_ready_2 = t.r2;
        @(posedge clk);
        #1;
        chk(nm, t.e);
    endtask

    vec_t tbl[19];
    vec_t t;

    initial begin
        // pkt A: 4 beats to out1; pkt B: sel flips mid-packet; pkt C: to out2;
        // pkt D: 5 beats to out2 under backpressure
        //          sel d      v  l  r1 r2 | sr v1 d1     l1 v2 d2     l2 c1 c2
        tbl[0]  = mk(0, 8'h11, 1, 0, 1, 1,   1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 8'h12, 1, 0, 1, 1,   1, 1, 8'h12, 0, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(0, 8'h13, 1, 0, 1, 1,   1, 1, 8'h13, 0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 8'h14, 1, 1, 1, 1,   1, 1, 8'h14, 1, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        tbl[5]  = mk(0, 8'h21, 1, 0, 1, 1,   1, 1, 8'h21, 0, 0, 8'h00, 0, 1, 0);
        tbl[6]  = mk(1, 8'h22, 1, 0, 1, 1,   1, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0);
        tbl[7]  = mk(1, 8'h23, 1, 1, 1, 1,   1, 1, 8'h23, 1, 0, 8'h00, 0, 1, 0);
        tbl[8]  = mk(1, 8'h31, 1, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'h31, 0, 2, 0);
        tbl[9]  = mk(1, 8'h32, 1, 1, 1, 1,   1, 0, 8'h00, 0, 1, 8'h32, 1, 2, 0);
        tbl[10] = mk(1, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1);
        tbl[11] = mk(1, 8'h41, 1, 0, 1, 0,   1, 0, 8'h00, 0, 1, 8'h41, 0, 2, 1);
        tbl[12] = mk(1, 8'h42, 1, 0, 1, 0,   0, 0, 8'h00, 0, 1, 8'h41, 0, 2, 1);
        tbl[13] = mk(1, 8'h43, 1, 0, 1, 0,   0, 0, 8'h00, 0, 1, 8'h41, 0, 2, 1);
        tbl[14] = mk(1, 8'h43, 1, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'h42, 0, 2, 1);
        tbl[15] = mk(1, 8'h43, 1, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'h43, 0, 2, 1);
        tbl[16] = mk(1, 8'h44, 1, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'h44, 0, 2, 1);
        tbl[17] = mk(1, 8'h45, 1, 1, 1, 1,   1, 0, 8'h00, 0, 1, 8'h45, 1, 2, 1);
        tbl[18] = mk(1, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 2, 2);

        reset_n = 1'b0; sel = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        m_ready_1 = 1'b1; m_ready_2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", mk(0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0).e);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++)
            apply($sformatf("tbl%0d", i), tbl[i]);

        // back-to-back single-beat packets alternating outputs
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                t = mk(0, 8'(8'h50 + i), 1, 1, 1, 1, 1, 1, 8'(8'h50 + i), 1, 0, 8'h00, 0,
                       2 + (i + 1) / 2, 2 + i / 2);
            else
                t = mk(1, 8'(8'h50 + i), 1, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'(8'h50 + i), 1,
                       2 + (i + 1) / 2, 2 + i / 2);
            apply($sformatf("alt%0d", i), t);
        end
        apply("alt_drain", mk(1, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 7, 7));

        // reset mid-packet with two beats parked in slice 1
        apply("rst_b1", mk(0, 8'h61, 1, 0, 0, 1, 1, 1, 8'h61, 0, 0, 8'h00, 0, 7, 7));
        apply("rst_b2", mk(0, 8'h62, 1, 0, 0, 1, 0, 1, 8'h61, 0, 0, 8'h00, 0, 7, 7));
        s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_async", mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0).e);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // IDLE again: sel=1 single beat must go to output 2
        apply("rst_after", mk(1, 8'h70, 1, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h70, 1, 0, 0));

        // 17 packets to output 1 -> counter wraps to 1 with CNT_W=4
        for (int i = 0; i < 17; i++)
            apply($sformatf("wrap%0d", i),
                  mk(0, 8'(i + 1), 1, 1, 1, 1, 1, 1, 8'(i + 1), 1, 0, 8'h00, 0, i, 1));
        apply("wrap_drain", mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 17, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_demux_1to2.md
# axis_demux_1to2

Packet-aware 1:2 AXI-Stream demultiplexer: accepts one byte stream on a slave port and steers each complete packet to one of two master ports, selected by `sel`. It is the fan-out counterpart of the 2:1 stream mux. Routing is locked per packet from first beat to `s_last`. Each output has a 2-entry skid buffer, so throughput is one beat per cycle and `s_ready` has no combinational path from `m_ready_*`.

## Interface
- `DATA_W`, 8, data width of all ports
- `CNT_W`, 16, width of per-output packet counters
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `sel`  in  1  route select: 0 -> output 1, 1 -> output 2; sampled only at packet start
- `s_data`  in  DATA_W  slave data
- `s_valid`  in  1  slave valid
- `s_ready`  out  1  slave ready
- `s_last`  in  1  last beat of packet
- `m_data_1` / `m_data_2`  out  DATA_W  master data
- `m_valid_1` / `m_valid_2`  out  1  master valid
- `m_ready_1` / `m_ready_2`  in  1  master ready
- `m_last_1` / `m_last_2`  out  1  master last
- `pkt_cnt_1` / `pkt_cnt_2`  out  CNT_W  delivered-packet counters (see Configuration)

## Operation
- Beat accepted on slave when `s_valid && s_ready` at a rising edge; delivered on master k when `m_valid_k && m_ready_k`.
- FSM, states IDLE, ROUTE_1, ROUTE_2:
  - IDLE: target = `sel` (combinational). Accepted beat with `s_last=0` -> ROUTE_1 (sel=0) or ROUTE_2 (sel=1). Accepted beat with `s_last=1` (single-beat packet) stays IDLE.
  - ROUTE_k: `sel` ignored; all beats go to output k. Accepted beat with `s_last=1` -> IDLE.
- `s_ready` = selected slice not full (count < 2). Derived from registered state, slice counts, and, in IDLE only, `sel`.
- The non-selected output keeps draining independently. Both outputs may present valid data in the same cycle.
- Skid slice per output: 2-entry FIFO of {data, last}, count 0..2. Push and pop in the same cycle leaves the count unchanged. Order is preserved.
- `m_valid_k` = count_k != 0. `m_data_k`/`m_last_k` = head entry, held stable while `m_valid_k && !m_ready_k`.
- Output data in an empty slice = 0.

## Timing
- Reset (`reset_n`=0, async assert, sync release): state IDLE, slice counts 0, `m_valid_*`=0, `m_data_*`=0, `m_last_*`=0, `s_ready`=1, `pkt_cnt_*`=0.
- Latency: beat accepted at edge N is visible on `m_*_k` from edge N (valid during cycle N+1) if slice k was empty.
- Throughput: 1 beat/cycle sustained while `m_ready_k`=1.
- Backpressure: `m_ready_k`=0 lets 2 beats buffer, then `s_ready` drops in the following cycle.
- Reset mid-packet: slice contents and the partial packet are discarded, and the FSM returns to IDLE. No recovery of the stream is attempted.
- `sel` toggling mid-packet has no effect until the cycle after the last beat is accepted.

## Configuration
- `AXIS_DEMUX_PKT_CNT_EN` defined:
  - `pkt_cnt_k` increments by 1 on each delivered beat with `m_last_k`=1.
  - Wraps modulo 2^CNT_W.
  - Both outputs may increment in the same cycle.
- Not defined: counter logic omitted; `pkt_cnt_1`/`pkt_cnt_2` tied to 0. Ports remain present.

## Test plan
- Reset then 4-beat packet 0x11..0x14 with `sel`=0 and `m_ready_1`=1 -> data on output 1 on consecutive cycles, `m_last_1` on 0x14, output 2 never valid, `pkt_cnt_1`=1 (macro on).
- `sel`=0 at beat 1, `sel`=1 from beat 2 of a 3-beat packet -> all 3 beats on output 1. The next packet, started with `sel`=1, goes to output 2.
- `m_ready_2`=0 during a 5-beat packet to output 2 -> 2 beats buffered, `s_ready`=0 after the second. Releasing `m_ready_2` delivers all 5 in order, with no loss or duplicates.
- Back-to-back single-beat packets alternating `sel` 0/1 with both readies high -> each output receives every other beat at full rate, `m_last_*`=1 on each. Counters equal after 10 packets (5 each).
- Assert `reset_n`=0 for 1 cycle mid-packet with 2 beats buffered -> outputs invalid immediately, `s_ready`=1 after release, FSM in IDLE honouring `sel` on the next beat.
- Macro on, `CNT_W`=4: deliver 17 packets to output 1 -> `pkt_cnt_1`=1 (wrap). Macro off -> `pkt_cnt_*` remain 0.
